priority_decoder32: RTL and testbench

PRIORITY_DECODER32 -- requirements
Module: priority_decoder32

---
 rtl/priority_codec_pkg.sv | 13 +
 rtl/priority_decoder32_if.sv | 27 ++
 rtl/decoder5to32.sv | 12 +
 rtl/priority_decoder32.sv | 104 ++++++++++
 tb/tb_priority_decoder32.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/priority_codec_pkg.sv
// rtl/priority_codec_pkg.sv - shared widths and control-state enum for the priority codec family
package priority_codec_pkg;

   localparam int VEC_W = 32;
   localparam int IDX_W = 5;
   localparam int CNT_W = 6;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_e;

endpackage : priority_codec_pkg

// File: rtl/priority_decoder32_if.sv
// rtl/priority_decoder32_if.sv - index-beat input stream and reconstructed-vector output stream
interface priority_decoder32_if;
   import priority_codec_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_index;
   logic             in_empty;
   logic             in_last;

   logic             out_valid;
   logic             out_ready;
   logic [VEC_W-1:0] out_vec;
   logic [CNT_W-1:0] out_count;
   logic             out_dup;

   modport master (
      output in_valid, in_index, in_empty, in_last, out_ready,
      input  in_ready, out_valid, out_vec, out_count, out_dup
   );

   modport slave (
      input  in_valid, in_index, in_empty, in_last, out_ready,
      output in_ready, out_valid, out_vec, out_count, out_dup
   );

endinterface : priority_decoder32_if

// File: rtl/decoder5to32.sv
// rtl/decoder5to32.sv - 5-bit index to 32-bit one-hot, all zeros when disabled
module decoder5to32
   import priority_codec_pkg::*;
(
   input  logic             en_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic [VEC_W-1:0] onehot_o
);

   assign onehot_o = en_i ? (VEC_W'(1) << idx_i) : '0;

endmodule : decoder5to32

// File: rtl/priority_decoder32.sv
// rtl/priority_decoder32.sv - rebuilds a bit vector from a stream of encoder index beats
// One vector per in_last; output is a one-deep registered slot with COLLECT/PRESENT control.
module priority_decoder32
   import priority_codec_pkg::*;
#(
   parameter int VEC_W = 32,
   parameter int IDX_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   priority_decoder32_if.slave bus
);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] acc_q, acc_d;
   logic [IDX_W:0]   cnt_q, cnt_d;
   logic             dup_q, dup_d;
   logic [VEC_W-1:0] out_vec_q, out_vec_d;
   logic [IDX_W:0]   out_count_q, out_count_d;
   logic             out_dup_q, out_dup_d;

   logic             out_valid;
   logic             accept;
   logic             last_acc;
   logic [VEC_W-1:0] hot;
   logic [VEC_W-1:0] acc_merged;
   logic [IDX_W:0]   cnt_merged;
   logic             dup_merged;
   logic             is_new;
   logic             is_dup;

   assign out_valid    = (state_q == PRESENT);
   assign bus.in_ready = !out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_acc     = accept && bus.in_last;

   decoder5to32 u_dec (
      .en_i     (accept && !bus.in_empty),
      .idx_i    (bus.in_index),
      .onehot_o (hot)
   );

   // hot is zero for empty or unaccepted beats, so both flags fall out naturally
   assign is_new     = |(hot & ~acc_q);
   assign is_dup     = |(hot & acc_q);
   assign acc_merged = acc_q | hot;
   assign cnt_merged = cnt_q + {{IDX_W{1'b0}}, is_new};
   assign dup_merged = dup_q | is_dup;

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (last_acc) state_d = PRESENT;
         PRESENT: if (!last_acc && bus.out_ready) state_d = COLLECT;
      endcase
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      dup_d       = dup_q;
      out_vec_d   = out_vec_q;
      out_count_d = out_count_q;
      out_dup_d   = out_dup_q;
      if (last_acc) begin
         out_vec_d   = acc_merged;
         out_count_d = cnt_merged;
         out_dup_d   = dup_merged;
         acc_d       = '0;
         cnt_d       = '0;
         dup_d       = 1'b0;
      end else if (accept) begin
         acc_d = acc_merged;
         cnt_d = cnt_merged;
         dup_d = dup_merged;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= COLLECT;
         acc_q       <= '0;
         cnt_q       <= '0;
         dup_q       <= 1'b0;
         out_vec_q   <= '0;
         out_count_q <= '0;
         out_dup_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         dup_q       <= dup_d;
         out_vec_q   <= out_vec_d;
         out_count_q <= out_count_d;
         out_dup_q   <= out_dup_d;
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_vec   = out_vec_q;
   assign bus.out_count = out_count_q;
   assign bus.out_dup   = out_dup_q;

endmodule : priority_decoder32

// File: tb/tb_priority_decoder32.sv
// tb/tb_priority_decoder32.sv - directed self-checking bench for priority_decoder32
module tb_priority_decoder32;

   logic clk;
   logic rst;
   int   total;
   int   passed;
   int   failed;

   priority_decoder32_if bus ();

   priority_decoder32 #(.VEC_W(32), .IDX_W(5)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] vec,
                          input logic [5:0] cnt, input logic dup);
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
      chk({tag, "_vec"},   64'(bus.out_vec),   64'(vec));
      chk({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
      chk({tag, "_dup"},   64'(bus.out_dup),   64'(dup));
   endtask

   task automatic beat(input logic [4:0] idx, input logic empty, input logic last);
      int waited;
      bus.in_valid = 1'b1;
      bus.in_index = idx;
      bus.in_empty = empty;
      bus.in_last  = last;
      waited = 0;
      #1;
      while (!bus.in_ready && waited < 16) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (waited >= 16) chk("beat_ready_timeout", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_empty = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      failed = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_index  = '0;
      bus.in_empty  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      #3;
      chk_out("reset", 1'b0, 32'h0, 6'd0, 1'b0);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

      // single beat with last
      beat(5'd31, 1'b0, 1'b1);
      chk_out("single31", 1'b1, 32'h8000_0000, 6'd1, 1'b0);
      idle();
      chk("single31_drain", 64'(bus.out_valid), 64'd0);

      // four distinct indices
      beat(5'd0, 1'b0, 1'b0);
      chk("acc_no_valid", 64'(bus.out_valid), 64'd0);
      beat(5'd7, 1'b0, 1'b0);
      beat(5'd16, 1'b0, 1'b0);
      beat(5'd31, 1'b0, 1'b1);
      chk_out("four", 1'b1, 32'h8001_0081, 6'd4, 1'b0);
      idle();
      chk("four_drain", 64'(bus.out_valid), 64'd0);

      // duplicate index, then a clean vector loaded back-to-back while presenting
      beat(5'd3, 1'b0, 1'b0);
      beat(5'd3, 1'b0, 1'b0);
      beat(5'd5, 1'b0, 1'b1);
      chk_out("dup", 1'b1, 32'h0000_0028, 6'd2, 1'b1);
      beat(5'd9, 1'b0, 1'b1);
      chk_out("after_dup", 1'b1, 32'h0000_0200, 6'd1, 1'b0);
      idle();
      chk("after_dup_drain", 64'(bus.out_valid), 64'd0);

      // empty beat in the middle must ignore its index
      beat(5'd8, 1'b0, 1'b0);
      beat(5'd3, 1'b1, 1'b0);
      beat(5'd8, 1'b0, 1'b1);
      chk_out("empty_mid", 1'b1, 32'h0000_0100, 6'd1, 1'b1);
      idle();

      // backpressure with a second last beat waiting
      bus.out_ready = 1'b0;
      beat(5'd2, 1'b0, 1'b1);
      chk_out("bp_first", 1'b1, 32'h0000_0004, 6'd1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_index = 5'd6;
      bus.in_last  = 1'b1;
      #1;
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      idle();
      chk_out("bp_stable", 1'b1, 32'h0000_0004, 6'd1, 1'b0);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk_out("bp_second", 1'b1, 32'h0000_0040, 6'd1, 1'b0);
      idle();
      chk("bp_drain", 64'(bus.out_valid), 64'd0);

      // reset mid-vector discards partial accumulation
      beat(5'd1, 1'b0, 1'b0);
      beat(5'd2, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk_out("async_reset", 1'b0, 32'h0, 6'd0, 1'b0);
      chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      beat(5'd4, 1'b0, 1'b1);
      chk_out("post_reset_vec", 1'b1, 32'h0000_0010, 6'd1, 1'b0);
      idle();

      // empty vector, then every index
      beat(5'd17, 1'b1, 1'b1);
      chk_out("empty_vec", 1'b1, 32'h0, 6'd0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         beat(5'(i), 1'b0, (i == 31));
      end
      chk_out("all32", 1'b1, 32'hFFFF_FFFF, 6'd32, 1'b0);
      idle();
      chk("all32_drain", 64'(bus.out_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_priority_decoder32
